// File: rtl/sd_boot_loader.sv
// Boot sequencer: fetches a MAGIC/LEN-headed image from the SD controller into instruction RAM,
// then releases the CPU. Define BOOT_CHECKSUM_EN to fetch and verify a trailing checksum word.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for boot_start_i after reset
// REQ       | present the SD address of word idx and raise word_req_o
// WAIT      | hold the request until word_valid_i or timeout
// HDR_MAGIC | compare captured word against MAGIC
// HDR_LEN   | range-check and latch the payload length
// LOAD      | RAM write issued; accumulate and advance the index
// CHECK     | compare trailing checksum word against the accumulator
// DONE      | image loaded, CPU released
// ERROR     | aborted, err_code_o latched, CPU held in reset
module sd_boot_loader #(
  parameter int          MEM_AW       = 12,
  parameter logic [31:0] SD_BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP    = 32'd4,
  parameter logic [31:0] MAGIC        = 32'h5369_5250,
  parameter logic [19:0] TIMEOUT_CYC  = 20'hF_FFFF
) (
  input  logic              boot_clk_i,
  input  logic              boot_rst_i,
  input  logic              boot_start_i,
  input  logic              word_valid_i,
  input  logic [31:0]       word_data_i,
  output logic [31:0]       sd_address_o,
  output logic              word_req_o,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  output logic              cpu_rst_o,
  output logic              boot_done_o,
  output logic              boot_err_o,
  output logic [2:0]        err_code_o
);

  localparam int          IW      = MEM_AW + 2;
  localparam logic [31:0] MAX_LEN = 32'(1) << MEM_AW;

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_WAIT, S_HDR_MAGIC, S_HDR_LEN, S_LOAD, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   len_q;
  logic [IW-1:0]   idx_m2;
  logic [31:0]     word_q;
  logic [19:0]     tmo_q;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0]     sum_q;
`endif

  assign idx_m2 = idx_q - IW'(2);

  always_ff @(posedge boot_clk_i or negedge boot_rst_i) begin
    if (!boot_rst_i) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      len_q        <= '0;
      word_q       <= '0;
      tmo_q        <= '0;
      sd_address_o <= SD_BASE_ADDR;
      word_req_o   <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      cpu_rst_o    <= 1'b1;
      boot_done_o  <= 1'b0;
      boot_err_o   <= 1'b0;
      err_code_o   <= 3'd0;
`ifdef BOOT_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      mem_we_o <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (boot_start_i) begin
            idx_q       <= '0;
            err_code_o  <= 3'd0;
            boot_done_o <= 1'b0;
            boot_err_o  <= 1'b0;
            cpu_rst_o   <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
            sum_q       <= '0;
`endif
            state_q     <= S_REQ;
          end
        end
        S_REQ: begin
          sd_address_o <= SD_BASE_ADDR + 32'(idx_q) * ADDR_STEP;
          word_req_o   <= 1'b1;
          tmo_q        <= '0;
          state_q      <= S_WAIT;
        end
        S_WAIT: begin
          // a valid strobe in the timeout cycle still counts as a delivered word
          if (word_valid_i) begin
            word_q     <= word_data_i;
            word_req_o <= 1'b0;
            tmo_q      <= '0;
            if (idx_q == IW'(0)) begin
              state_q <= S_HDR_MAGIC;
            end else if (idx_q == IW'(1)) begin
              state_q <= S_HDR_LEN;
`ifdef BOOT_CHECKSUM_EN
            end else if (idx_q == len_q + IW'(2)) begin
              state_q <= S_CHECK;
`endif
            end else begin
              // RAM write issued here so it lands one cycle after the strobe
              mem_we_o   <= 1'b1;
              mem_addr_o <= idx_m2[MEM_AW-1:0];
              mem_data_o <= word_data_i;
              state_q    <= S_LOAD;
            end
          end else if (tmo_q == TIMEOUT_CYC - 20'd1) begin
            word_req_o <= 1'b0;
            boot_err_o <= 1'b1;
            err_code_o <= 3'd3;
            state_q    <= S_ERROR;
          end else begin
            tmo_q <= tmo_q + 20'd1;
          end
        end
        S_HDR_MAGIC: begin
          if (word_q != MAGIC) begin
            boot_err_o <= 1'b1;
            err_code_o <= 3'd1;
            state_q    <= S_ERROR;
          end else begin
            idx_q   <= idx_q + IW'(1);
            state_q <= S_REQ;
          end
        end
        S_HDR_LEN: begin
          if (word_q == 32'd0 || word_q > MAX_LEN) begin
            boot_err_o <= 1'b1;
            err_code_o <= 3'd2;
            state_q    <= S_ERROR;
          end else begin
            len_q   <= word_q[IW-1:0];
            idx_q   <= idx_q + IW'(1);
            state_q <= S_REQ;
          end
        end
        S_LOAD: begin
          idx_q <= idx_q + IW'(1);
`ifdef BOOT_CHECKSUM_EN
          sum_q   <= sum_q + word_q;
          // after the last payload word the checksum word still has to be fetched
          state_q <= S_REQ;
`else
          if (idx_q == len_q + IW'(1)) begin
            cpu_rst_o   <= 1'b0;
            boot_done_o <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            state_q <= S_REQ;
          end
`endif
        end
`ifdef BOOT_CHECKSUM_EN
        S_CHECK: begin
          if (word_q != sum_q) begin
            boot_err_o <= 1'b1;
            err_code_o <= 3'd4;
            state_q    <= S_ERROR;
          end else begin
            cpu_rst_o   <= 1'b0;
            boot_done_o <= 1'b1;
            state_q     <= S_DONE;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sd_boot_loader.md
Name: sd_boot_loader

Overview:
- Boot sequencer between the SPI SD-card controller and the processor's instruction memory.
- Drives the SD read address to the controller and consumes each 32-bit word the controller returns.
- Checks a boot-image header, writes the payload into instruction RAM, then releases the CPU from reset.
- Holds the CPU in reset until the image is fully loaded, or latches an error code on failure.

Parameters:
- MEM_AW, 12: instruction RAM word-address width; maximum image is 2^MEM_AW words.
- SD_BASE_ADDR, 32'h0000_0000: SD address of the image header's first word.
- ADDR_STEP, 4: SD address increment per word.
- MAGIC, 32'h5369_5250: required first header word.
- TIMEOUT_CYC, 20'hF_FFFF: maximum cycles to wait for a word before aborting.

Ports:
- boot_clk_i  in  1  system clock.
- boot_rst_i  in  1  asynchronous, active-low reset.
- boot_start_i  in  1  one-cycle start pulse; ignored unless state is IDLE, DONE or ERROR.
- word_valid_i  in  1  one-cycle strobe from the SD controller: word_data_i is valid.
- word_data_i  in  32  word read from the SD card.
- sd_address_o  out  32  SD address of the requested word.
- word_req_o  out  1  read request to the SD controller.
- mem_we_o  out  1  instruction RAM write enable, one-cycle pulse.
- mem_addr_o  out  MEM_AW  instruction RAM word address.
- mem_data_o  out  32  instruction RAM write data.
- cpu_rst_o  out  1  active-high CPU reset; released only in DONE.
- boot_done_o  out  1  image loaded successfully.
- boot_err_o  out  1  load aborted.
- err_code_o  out  3  error code: 0 none, 1 bad magic, 2 bad length, 3 timeout, 4 checksum.

Behaviour:
- Reset values: sd_address_o=SD_BASE_ADDR, mem_addr_o=0, mem_data_o=0, cpu_rst_o=1, err_code_o=0; all other outputs 0. State after reset is IDLE.
- States: IDLE, REQ, WAIT, HDR_MAGIC, HDR_LEN, LOAD, CHECK, DONE, ERROR.
- Image layout, consecutive words from SD_BASE_ADDR: MAGIC, LEN (payload word count), LEN payload words, then the checksum word when BOOT_CHECKSUM_EN is defined.
- IDLE -> REQ on boot_start_i. This clears word index, checksum accumulator, err_code_o, boot_done_o and boot_err_o, and sets cpu_rst_o=1.
- REQ:
  - sd_address_o = SD_BASE_ADDR + index*ADDR_STEP, 32-bit wrap.
  - word_req_o=1; next state WAIT.
- WAIT:
  - word_req_o and sd_address_o are held stable; the timeout counter increments.
  - On word_valid_i: capture word_data_i, clear the counter, drop word_req_o, go to the phase selected by index.
  - Phase selection: index 0 -> HDR_MAGIC; index 1 -> HDR_LEN; 2..LEN+1 -> LOAD; LEN+2 -> CHECK.
  - Timeout: when the counter reaches TIMEOUT_CYC with no valid -> ERROR, code 3.
- word_valid_i outside WAIT is ignored: no state change, no write.
- Simultaneous word_valid_i and timeout in the same cycle: valid wins.
- HDR_MAGIC: captured word != MAGIC -> ERROR code 1; otherwise index+1 and go to REQ.
- HDR_LEN:
  - LEN==0 or LEN>2^MEM_AW -> ERROR code 2.
  - Otherwise latch LEN, index+1, REQ.
- LOAD:
  - mem_we_o=1 for exactly one cycle with mem_addr_o=index-2 and mem_data_o=captured word. This is 1 cycle after word_valid_i.
  - Accumulator += word, mod 2^32. MAGIC and LEN are excluded from the sum.
  - index+1. If the last payload word was written -> CHECK when checksum is enabled, else DONE; otherwise REQ.
- CHECK: captured word != accumulator -> ERROR code 4; else DONE.
- DONE: cpu_rst_o=0, boot_done_o=1; both held until the next start or reset.
- ERROR: boot_err_o=1, err_code_o held, cpu_rst_o=1; RAM contents are left as written.
- boot_start_i in DONE or ERROR restarts the full sequence and reasserts cpu_rst_o the next cycle.
- Reset asserted mid-load: immediate return to reset values. A partially written RAM is not cleaned up.
- Index counter width: MEM_AW+2 bits, so no overflow occurs for the maximum LEN.

Optional Feature:
- Macro: BOOT_CHECKSUM_EN.
- Defined: the trailing checksum word is requested and checked in the CHECK state; a mismatch gives code 4.
- Undefined: no checksum word is requested, the CHECK state and accumulator are not built, the last payload write goes straight to DONE, and code 4 is never produced.

Test Plan:
- Valid image: MAGIC, LEN=3, words 0x11,0x22,0x33, checksum 0x66 (when enabled). Required response:
  - sd_address_o steps 0,4,8,...
  - RAM writes addr0=0x11, addr1=0x22, addr2=0x33.
  - boot_done_o=1, cpu_rst_o=0, err_code_o=0.
- First word 0xDEADBEEF -> ERROR, err_code_o=1, no mem_we_o pulse, cpu_rst_o stays 1.
- LEN=0 -> err_code_o=2; LEN=2^MEM_AW+1 -> err_code_o=2; LEN=2^MEM_AW -> accepted, last write to mem_addr_o=all-ones.
- No word_valid_i after a request -> error with err_code_o=3 exactly TIMEOUT_CYC cycles after entering WAIT; sd_address_o stable throughout.
- Checksum enabled, trailing word 0x67 instead of 0x66 -> err_code_o=4; then boot_start_i with a good image -> boot_done_o=1.
- boot_rst_i low during payload word 2 -> all outputs return to reset values asynchronously; stray word_valid_i in IDLE -> no write.
